// File: rtl/race_tree_controller.sv
// Drag-race light tree sequencer with per-lane foul detection and reaction timing.
// Define RACE_TREE_FOUL_ABORT_EN to jump straight to FINAL once any lane fouls.
module race_tree_controller #(
  parameter int LANES     = 2,
  parameter int STAGE_CYC = 3,
  parameter int GAP_CYC   = 1,
  parameter int RT_W      = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [LANES-1:0]      launch,
  output logic                  red,
  output logic                  yellow,
  output logic                  green,
  output logic                  busy,
  output logic                  done,
  output logic [LANES-1:0]      foul,
  output logic [LANES-1:0]      rt_valid,
  output logic [LANES*RT_W-1:0] rt
);

  localparam int MAX_CYC = (STAGE_CYC > GAP_CYC) ? STAGE_CYC : GAP_CYC;
  localparam int PH_W    = $clog2(MAX_CYC + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_RED, S_GAP1, S_YELLOW, S_GAP2, S_GREEN, S_GAP3, S_FINAL
  } state_t;

  state_t                  state_q, state_d;
  logic [PH_W-1:0]         phase_q, phase_d;
  logic [RT_W-1:0]         rtc_q, rtc_d;
  logic [LANES-1:0]        foul_q, foul_d;
  logic [LANES-1:0]        rt_valid_q, rt_valid_d;
  logic [LANES*RT_W-1:0]   rt_q, rt_d;

  logic rearm;
  logic in_pre;
  logic in_post;
  logic all_done;

  function automatic int phase_len(input state_t s);
    case (s)
      S_RED, S_YELLOW, S_GREEN: return STAGE_CYC;
      S_GAP1, S_GAP2, S_GAP3:   return GAP_CYC;
      default:                  return 1;
    endcase
  endfunction

  // With no dark gap configured each colour hands straight to the next one.
  function automatic state_t after_phase(input state_t s);
    case (s)
      S_RED:    return (GAP_CYC == 0) ? S_YELLOW : S_GAP1;
      S_GAP1:   return S_YELLOW;
      S_YELLOW: return (GAP_CYC == 0) ? S_GREEN : S_GAP2;
      S_GAP2:   return S_GREEN;
      S_GREEN:  return (GAP_CYC == 0) ? S_FINAL : S_GAP3;
      S_GAP3:   return S_FINAL;
      default:  return s;
    endcase
  endfunction

  function automatic logic [RT_W-1:0] sat_inc(input logic [RT_W-1:0] v);
    return (&v) ? v : v + RT_W'(1);
  endfunction

  always_comb begin
    state_d    = state_q;
    phase_d    = phase_q;
    rtc_d      = rtc_q;
    foul_d     = foul_q;
    rt_valid_d = rt_valid_q;
    rt_d       = rt_q;

    rearm    = start && ((state_q == S_IDLE) || (state_q == S_FINAL));
    in_pre   = (state_q == S_RED) || (state_q == S_GAP1) ||
               (state_q == S_YELLOW) || (state_q == S_GAP2);
    in_post  = (state_q == S_GREEN) || (state_q == S_GAP3) || (state_q == S_FINAL);
    all_done = &(foul_q | rt_valid_q);

    case (state_q)
      S_IDLE, S_FINAL: begin
        if (start) begin
          state_d = S_RED;
          phase_d = '0;
        end
      end
      default: begin
        if (int'(phase_q) >= phase_len(state_q) - 1) begin
          state_d = after_phase(state_q);
          phase_d = '0;
        end else begin
          phase_d = phase_q + PH_W'(1);
        end
      end
    endcase

`ifdef RACE_TREE_FOUL_ABORT_EN
    if (in_pre || (state_q == S_GREEN) || (state_q == S_GAP3)) begin
      if (|foul_q) begin
        state_d = S_FINAL;
        phase_d = '0;
      end
    end
`endif

    if (in_pre)
      foul_d = foul_q | launch;

    // First clean launch per lane latches the running counter; later launches are ignored.
    if (in_post && !rearm) begin
      for (int i = 0; i < LANES; i++) begin
        if (launch[i] && !foul_q[i] && !rt_valid_q[i]) begin
          rt_d[i*RT_W +: RT_W] = rtc_q;
          rt_valid_d[i]        = 1'b1;
        end
      end
    end

    if ((state_d == S_GREEN) && (state_q != S_GREEN))
      rtc_d = '0;
    else if (in_post && !all_done)
      rtc_d = sat_inc(rtc_q);

    if (rearm) begin
      foul_d     = '0;
      rt_valid_d = '0;
      rt_d       = '0;
      rtc_d      = '0;
    end
  end

  always_ff @(negedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      phase_q    <= '0;
      rtc_q      <= '0;
      foul_q     <= '0;
      rt_valid_q <= '0;
      rt_q       <= '0;
    end else begin
      state_q    <= state_d;
      phase_q    <= phase_d;
      rtc_q      <= rtc_d;
      foul_q     <= foul_d;
      rt_valid_q <= rt_valid_d;
      rt_q       <= rt_d;
    end
  end

  always_comb begin
    red    = (state_q == S_IDLE) || (state_q == S_RED) || (state_q == S_FINAL);
    yellow = (state_q == S_YELLOW);
    green  = (state_q == S_GREEN);
    busy   = (state_q != S_IDLE) && (state_q != S_FINAL);
    done   = (state_q == S_FINAL);
  end

  assign foul     = foul_q;
  assign rt_valid = rt_valid_q;
  assign rt       = rt_q;

endmodule

// File: tb/tb_race_tree_controller.sv
// Directed bench for race_tree_controller: default, gapless and narrow-counter builds.
module tb_race_tree_controller;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  logic       start0 = 0, start1 = 0, start2 = 0;
  logic [1:0] launch0 = '0, launch1 = '0, launch2 = '0;

  logic red0, yellow0, green0, busy0, done0;
  logic red1, yellow1, green1, busy1, done1;
  logic red2, yellow2, green2, busy2, done2;
  logic [1:0]  foul0, foul1, foul2, rtv0, rtv1, rtv2;
  logic [31:0] rt0, rt1;
  logic [5:0]  rt2;

  race_tree_controller #(.LANES(2), .STAGE_CYC(3), .GAP_CYC(1), .RT_W(16)) dut0 (
    .clk(clk), .rst(rst), .start(start0), .launch(launch0),
    .red(red0), .yellow(yellow0), .green(green0), .busy(busy0), .done(done0),
    .foul(foul0), .rt_valid(rtv0), .rt(rt0));

  race_tree_controller #(.LANES(2), .STAGE_CYC(2), .GAP_CYC(0), .RT_W(16)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .launch(launch1),
    .red(red1), .yellow(yellow1), .green(green1), .busy(busy1), .done(done1),
    .foul(foul1), .rt_valid(rtv1), .rt(rt1));

  race_tree_controller #(.LANES(2), .STAGE_CYC(3), .GAP_CYC(1), .RT_W(3)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .launch(launch2),
    .red(red2), .yellow(yellow2), .green(green2), .busy(busy2), .done(done2),
    .foul(foul2), .rt_valid(rtv2), .rt(rt2));

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Lamp vector {red,yellow,green,busy,done} for cycle c after a start sampled at edge 0.
  function automatic logic [4:0] exp_lamps(input int c, input int stg, input int gap,
                                           input bit from_final);
    int p;
    if (c == 0) return from_final ? 5'b10001 : 5'b10000;
    p = c - 1;
    if (p < stg) return 5'b10010;
    p -= stg;
    if (p < gap) return 5'b00010;
    p -= gap;
    if (p < stg) return 5'b01010;
    p -= stg;
    if (p < gap) return 5'b00010;
    p -= gap;
    if (p < stg) return 5'b00110;
    p -= stg;
    if (p < gap) return 5'b00010;
    return 5'b10001;
  endfunction

  // Enter just after a falling edge; cycle c shows the state sampled at edge c.
  task automatic run(input int dut, input int ncyc, input int l0, input int l1,
                     input bit from_final);
    logic [4:0] lamps;
    int stg, gap;
    stg = (dut == 1) ? 2 : 3;
    gap = (dut == 1) ? 0 : 1;
    for (int c = 0; c < ncyc; c++) begin
      case (dut)
        0:       lamps = {red0, yellow0, green0, busy0, done0};
        1:       lamps = {red1, yellow1, green1, busy1, done1};
        default: lamps = {red2, yellow2, green2, busy2, done2};
      endcase
      check_eq($sformatf("dut%0d lamps c%0d", dut, c), 64'(lamps),
               64'(exp_lamps(c, stg, gap, from_final)));
      case (dut)
        0: begin start0 = (c == 0); launch0 = {c == l1, c == l0}; end
        1: begin start1 = (c == 0); launch1 = {c == l1, c == l0}; end
        default: begin start2 = (c == 0); launch2 = {c == l1, c == l0}; end
      endcase
      @(negedge clk);
      #1;
    end
    start0 = 0; start1 = 0; start2 = 0;
    launch0 = '0; launch1 = '0; launch2 = '0;
  endtask

  initial begin
    #2;
    check_eq("reset lamps", 64'({red0, yellow0, green0, busy0, done0}), 64'(5'b10000));
    check_eq("reset foul", 64'(foul0), 64'(0));
    check_eq("reset rt_valid", 64'(rtv0), 64'(0));
    check_eq("reset rt", 64'(rt0), 64'(0));
    #1 rst = 0;
    @(negedge clk);
    #1;

    run(0, 16, -1, -1, 1'b0);
    check_eq("no-launch rt_valid", 64'(rtv0), 64'(0));
    check_eq("no-launch foul", 64'(foul0), 64'(0));

    run(0, 17, 9, 14, 1'b1);
    check_eq("timed rt0", 64'(rt0[15:0]), 64'(0));
    check_eq("timed rt1", 64'(rt0[31:16]), 64'(5));
    check_eq("timed rt_valid", 64'(rtv0), 64'(2'b11));
    check_eq("timed foul", 64'(foul0), 64'(0));

    run(0, 16, 10, 6, 1'b1);
    check_eq("yellow foul", 64'(foul0), 64'(2'b10));
    check_eq("yellow foul rt_valid", 64'(rtv0), 64'(2'b01));
    check_eq("yellow foul rt0", 64'(rt0[15:0]), 64'(1));

    run(0, 16, 8, 9, 1'b1);
    check_eq("gap2 edge foul", 64'(foul0), 64'(2'b01));
    check_eq("green edge rt_valid", 64'(rtv0), 64'(2'b10));
    check_eq("green edge rt1", 64'(rt0[31:16]), 64'(0));

    run(0, 7, 2, -1, 1'b1);
    check_eq("pre-abort yellow", 64'(yellow0), 64'(1));
    check_eq("pre-abort foul", 64'(foul0), 64'(2'b01));
    rst = 1;
    #1;
    check_eq("abort lamps", 64'({red0, yellow0, green0, busy0, done0}), 64'(5'b10000));
    check_eq("abort foul", 64'(foul0), 64'(0));
    rst = 0;
    @(negedge clk);
    #1;
    run(0, 16, -1, -1, 1'b0);
    check_eq("post-abort foul", 64'(foul0), 64'(0));

    run(1, 10, 5, -1, 1'b0);
    check_eq("gapless rt_valid", 64'(rtv1), 64'(2'b01));
    check_eq("gapless rt0", 64'(rt1[15:0]), 64'(0));

    run(2, 21, 19, -1, 1'b0);
    check_eq("sat rt0", 64'(rt2[2:0]), 64'(7));
    check_eq("sat rt_valid", 64'(rtv2), 64'(2'b01));
    run(2, 2, -1, -1, 1'b1);
    check_eq("rearm rt_valid", 64'(rtv2), 64'(0));
    check_eq("rearm rt", 64'(rt2), 64'(0));
    check_eq("rearm busy", 64'(busy2), 64'(1));

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/race_tree_controller.md
# race_tree_controller

Parametrised drag-race light tree sequencer: on a start request it steps a shared red/yellow/green tree through timed phases, then checks each lane's launch sensor for fouls (early launch) and measures per-lane reaction time from green. It generalises the fixed single-lane race light controller. Adds configurable phase lengths, N lanes, foul detection, reaction timing and re-arming for back-to-back races. Sits between the start/launch sensor front end and the scoreboard/display logic.

## Interface
- LANES, 2, number of lanes with launch sensors (>=1)
- STAGE_CYC, 3, clock cycles each colour phase (red, yellow, green) is lit (>=1)
- GAP_CYC, 1, dark cycles between colour phases (>=0; 0 removes gap states)
- RT_W, 16, reaction-time counter width per lane

- clk  input  1  clock; all state updates on the falling edge
- rst  input  1  asynchronous, active-high reset
- start  input  1  race request, level sampled each falling edge
- launch  input  LANES  per-lane launch sensor, high = car has left the line
- red, yellow, green  output  1 each  tree lamps
- busy  output  1  high from RED through GAP3
- done  output  1  high in FINAL
- foul  output  LANES  sticky per-lane early-launch flag
- rt_valid  output  LANES  sticky per-lane reaction time captured
- rt  output  LANES*RT_W  lane i reaction time in rt[i*RT_W +: RT_W]

## Operation
- States: IDLE, RED, GAP1, YELLOW, GAP2, GREEN, GAP3, FINAL. Phase counter counts cycles within a state.
- IDLE: red=1. start=1 at an edge -> RED; clear foul, rt_valid, rt.
- RED/YELLOW/GREEN: lamp lit for STAGE_CYC cycles, then next gap state (or next colour when GAP_CYC=0). GREEN -> GAP3 -> FINAL.
- GAP1/GAP2/GAP3: all lamps off for GAP_CYC cycles.
- FINAL: red=1, done=1. start=1 -> RED (re-arm, same clear as IDLE); otherwise hold.
- start ignored in RED..GAP3.
- Lamps, busy, done are Moore decodes of the state register only; no input reaches an output combinationally.
- Foul: launch[i]=1 at any edge while state in {RED, GAP1, YELLOW, GAP2} sets foul[i]. Launch in IDLE is ignored.
- Reaction counter: set to 0 on entry to GREEN; +1 each edge while in {GREEN, GAP3, FINAL}; saturates at 2^RT_W-1; frozen once every lane is fouled or valid.
- Capture: at the first edge in {GREEN, GAP3, FINAL} with launch[i]=1, foul[i]=0 and rt_valid[i]=0, load rt[i] with the current counter value and set rt_valid[i]. Lanes never overwrite. A fouled lane never becomes valid.
- Multiple lanes launching on the same edge all capture the same value.

## Timing
- Reset (async, immediate, any state): state IDLE, red=1, yellow=0, green=0, busy=0, done=0, foul=0, rt_valid=0, rt=0, counters 0. Mid-race reset aborts with no residual flags.
- With start sampled at edge 0 and defaults: RED cycles 1-3, GAP1 4, YELLOW 5-7, GAP2 8, GREEN 9-11, GAP3 12, FINAL from 13.
- Launch sampled at the first GREEN edge gives rt=0. Each later edge adds 1.
- Launch sampled on the last GAP2 edge is a foul. Launch sampled on the next (first GREEN) edge is not.
- The GAP_CYC=0 path must skip gaps with no idle cycle.

## Configuration
- RACE_TREE_FOUL_ABORT_EN defined: any foul bit becoming set moves the state to FINAL at the next edge (red=1, done=1). Lanes not fouled stay rt_valid=0.
- Not defined: the sequence runs to completion regardless of fouls. Fouled lanes are only flagged.

## Test plan
- Defaults, start pulse at edge 0, no launches -> red 1-3, dark 4, yellow 5-7, dark 8, green 9-11, dark 12, done=1 from 13, rt_valid=0.
- LANES=2, launch[0] at edge 9, launch[1] at edge 14 -> rt[0]=0, rt[1]=5, both valid, foul=0.
- launch[1] high at edge 6 -> foul[1]=1, rt_valid[1] stays 0. With FOUL_ABORT_EN: FINAL at edge 7. Without: green still at 9-11.
- GAP_CYC=0, STAGE_CYC=2 -> red 1-2, yellow 3-4, green 5-6, FINAL at 7.
- rst asserted during YELLOW with foul[0] set -> immediate IDLE, red=1, foul=0. A new start gives a full sequence.
- RT_W=3, launch at edge 9+10 -> rt=7 (saturated). Start in FINAL -> flags cleared, RED next cycle.
